// File: rtl/iob_merge_rr.sv
`default_nettype none
// ============================================================================
//  Module   : iob_merge_rr
//  Purpose  : Round-robin merge of N native-bus masters onto one native-bus
//             slave port. The grant is registered and held for the whole
//             transaction; the response goes only to the granted master.
//  Ports    :
//    clk     - system clock
//    rst     - synchronous active-high reset
//    m_req   - N packed master requests {valid, addr, wdata, wstrb}
//    m_resp  - N packed master responses {rdata, ready}
//    s_req   - merged request to the slave
//    s_resp  - slave response {rdata, ready}
//    grant   - index of the currently granted master
//    busy    - high while a grant is held
//  Revision : 1.0 - initial release
// ============================================================================
module iob_merge_rr #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1,
    localparam int G_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [G_W-1:0]              grant,
    output logic                        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [G_W-1:0]         r_grant;
    logic [G_W-1:0]         w_grant_nxt;
    logic [G_W-1:0]         r_rr_ptr;
    logic [G_W-1:0]         w_rr_nxt;

    logic [N_MASTERS-1:0]   w_valid;
    logic [N_MASTERS-1:0]   w_others;
    logic [N_MASTERS-1:0]   w_ready;
    logic                   w_valid_granted;
    logic [G_W-1:0]         w_grant_inc;
    logic [G_W:0]           w_pick_idle;
    logic [G_W:0]           w_pick_re;

    // First requester at or above 'start', wrapping to the bottom.
    // Returns {found, index}.
    function automatic logic [G_W:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                             input logic [G_W-1:0]       start);
        logic           found;
        logic [G_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && req[i] && (i >= int'(start))) begin
                found = 1'b1;
                win   = G_W'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && req[i] && (i < int'(start))) begin
                found = 1'b1;
                win   = G_W'(i);
            end
        end
        return {found, win};
    endfunction

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_port
            assign w_valid[gi] = m_req[gi*REQ_W + REQ_W - 1];
            // rdata is broadcast; only the ready bit is steered.
            assign m_resp[gi*RESP_W +: RESP_W] = {s_resp[RESP_W-1:1], w_ready[gi]};
        end
    endgenerate

    // Wrapping increment for non-power-of-two master counts.
    assign w_grant_inc = (r_grant == G_W'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;

    // Rearbitration excludes the current grant: its valid in the ready
    // cycle still belongs to the request being retired.
    always_comb begin
        w_others        = '0;
        w_valid_granted = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_others[i] = w_valid[i] && (r_grant != G_W'(i));
            if (r_grant == G_W'(i)) begin
                w_valid_granted = w_valid[i];
            end
        end
    end

    assign w_pick_idle = rr_pick(w_valid, r_rr_ptr);
    assign w_pick_re   = rr_pick(w_others, w_grant_inc);

    // Request and response routing are combinational from the grant and
    // forced quiet during reset so a late slave ready is dropped.
    always_comb begin
        s_req   = '0;
        w_ready = '0;
        if (!rst && (r_state == S_BUSY)) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (r_grant == G_W'(i)) begin
                    s_req      = m_req[i*REQ_W +: REQ_W];
                    w_ready[i] = s_resp[0];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_pick_idle[G_W]) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_pick_idle[G_W-1:0];
                end
            end
            S_BUSY: begin
                if (s_resp[0]) begin
                    w_rr_nxt = w_grant_inc;
                    if (w_pick_re[G_W]) begin
                        w_grant_nxt = w_pick_re[G_W-1:0];
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!w_valid_granted) begin
                    // Master abandoned its request: release without a response.
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == S_BUSY);

endmodule
`default_nettype wire
